// File: rtl/tangcore_uart_pkg.sv
// Shared constants and types for the companion-MCU UART path.
// Holds message headers, requester slots and the arbiter state encoding.
package tangcore_uart_pkg;

    localparam logic [7:0] MSG_JOY     = 8'h01;
    localparam logic [7:0] MSG_CORE_ID = 8'h11;
    localparam logic [7:0] MSG_CONF    = 8'h22;

    localparam int REQ_RESP = 0;
    localparam int REQ_JOY  = 1;

    localparam int BAUD_RATE = 1_000_000;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arbState_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-one finder.
// The scan starts just after 'last' and reaches 'last' itself at the end.
module rr_pick
    import tangcore_uart_pkg::*;
#(
    parameter int N_REQ = 3
)
(
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic [$clog2(N_REQ)-1:0] pick,
    output logic                     any
);

    localparam int GW = $clog2(N_REQ);

    logic [2*N_REQ-1:0] w_reqDouble;
    logic [GW:0]        w_start;
    logic [N_REQ-1:0]   w_rotated;
    logic [GW:0]        w_offset;
    logic [GW+1:0]      w_sum;

    // Doubling the vector turns the wrap-around scan into a plain part-select.
    assign w_reqDouble = {req, req};
    assign w_start     = {1'b0, last} + (GW+1)'(1);
    assign w_rotated   = w_reqDouble[w_start +: N_REQ];

    always_comb begin
        w_offset = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rotated[k]) begin
                w_offset = (GW+1)'(k);
            end
        end
    end

    assign w_sum = {1'b0, w_start} + {1'b0, w_offset};
    assign pick  = (w_sum >= (GW+2)'(N_REQ)) ? GW'(w_sum - (GW+2)'(N_REQ)) : GW'(w_sum);
    assign any   = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among message sources.
// A grant is held for a full message; a stalled grantee is revoked after a timeout.
module uart_tx_arbiter
    import tangcore_uart_pkg::*;
#(
    parameter int N_REQ         = 3,
    parameter int STALL_TIMEOUT = 65535
)
(
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     abort
);

    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(STALL_TIMEOUT + 1);
    localparam logic [CW-1:0] STALL_MAX  = CW'(STALL_TIMEOUT);
    localparam logic [CW-1:0] STALL_LAST = CW'(STALL_TIMEOUT - 1);

    arbState_t      r_state;
    logic [GW-1:0]  r_grantId;
    logic           r_busy;
    logic [7:0]     r_txData;
    logic           r_txValid;
    logic           r_abort;
    logic [CW-1:0]  r_stallCnt;

    arbState_t      w_stateNext;
    logic [GW-1:0]  w_grantNext;
    logic           w_busyNext;
    logic [7:0]     w_txDataNext;
    logic           w_txValidNext;
    logic           w_abortNext;
    logic [CW-1:0]  w_stallNext;

    logic [GW-1:0]  w_pick;
    logic           w_any;
    logic           w_gValid;
    logic           w_gLast;
    logic [7:0]     w_gData;
    logic           w_accept;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req  (req_valid),
        .last (r_grantId),
        .pick (w_pick),
        .any  (w_any)
    );

    always_comb begin
        w_gValid = 1'b0;
        w_gLast  = 1'b0;
        w_gData  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grantId == GW'(i)) begin
                w_gValid = req_valid[i];
                w_gLast  = req_last[i];
                w_gData  = req_data[8*i +: 8];
            end
        end
    end

    // The ~tx_valid term keeps strobes apart even if tx_ready is slow to fall.
    assign w_accept = (r_state == SEND) & w_gValid & tx_ready & ~r_txValid;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grantId == GW'(i)) begin
                req_ready[i] = w_accept & resetn;
            end
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_grantNext   = r_grantId;
        w_busyNext    = r_busy;
        w_txDataNext  = r_txData;
        w_txValidNext = 1'b0;
        w_abortNext   = 1'b0;
        w_stallNext   = r_stallCnt;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_stateNext = SEND;
                    w_grantNext = w_pick;
                    w_busyNext  = 1'b1;
                    w_stallNext = '0;
                end
            end
            SEND: begin
                if (w_accept) begin
                    w_txValidNext = 1'b1;
                    w_txDataNext  = w_gData;
                    w_stallNext   = '0;
                    if (w_gLast) begin
                        w_stateNext = IDLE;
                        w_busyNext  = 1'b0;
                    end
                end else if (!w_gValid) begin
                    // Only a silent grantee counts; UART back-pressure never revokes.
                    if (r_stallCnt >= STALL_LAST) begin
                        w_stallNext = STALL_MAX;
                        w_abortNext = 1'b1;
                        w_stateNext = IDLE;
                        w_busyNext  = 1'b0;
                    end else begin
                        w_stallNext = r_stallCnt + CW'(1);
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_grantId  <= GW'(N_REQ - 1);
            r_busy     <= 1'b0;
            r_txData   <= '0;
            r_txValid  <= 1'b0;
            r_abort    <= 1'b0;
            r_stallCnt <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_grantId  <= w_grantNext;
            r_busy     <= w_busyNext;
            r_txData   <= w_txDataNext;
            r_txValid  <= w_txValidNext;
            r_abort    <= w_abortNext;
            r_stallCnt <= w_stallNext;
        end
    end

    assign tx_data  = r_txData;
    assign tx_valid = r_txValid;
    assign busy     = r_busy;
    assign grant_id = r_grantId;
    assign abort    = r_abort;

endmodule
